// File: rtl/ddr_addr_to_index_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ddr_index_pkg : DDR word address <-> line index shared constants     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package ddr_index_pkg;

  localparam int ADDR_W    = 12;
  localparam int INDEX_W   = 10;
  localparam int STRIDE    = 6;
  localparam int INDEX_MAX = 680;
  localparam int OFF_W     = 3;
  localparam int OOR_BASE  = STRIDE * INDEX_MAX;

  localparam int REM_W     = $clog2(STRIDE) + 1;
  localparam int CNT_W     = $clog2(ADDR_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ddr_addr_to_index_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ddr_addr_to_index_if : address-in / index-out handshake bundle       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface ddr_addr_to_index_if;
  import ddr_index_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [ADDR_W-1:0]  in_addr;
  logic               out_valid;
  logic               out_ready;
  logic [INDEX_W-1:0] out_index;
  logic [OFF_W-1:0]   out_offset;
  logic               out_oor;
  logic               busy;

  modport slave (
    input  in_valid, in_addr, out_ready,
    output in_ready, out_valid, out_index, out_offset, out_oor, busy
  );

  modport master (
    output in_valid, in_addr, out_ready,
    input  in_ready, out_valid, out_index, out_offset, out_oor, busy
  );

endinterface
`default_nettype wire

// File: rtl/ddr_addr_to_index_div_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ddr_div_step : one combinational radix-2 restoring divide step       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ddr_div_step
  import ddr_index_pkg::*;
(
  input  wire logic [REM_W-1:0] i_rem,
  input  wire logic             i_bit,
  output logic      [REM_W-1:0] o_rem,
  output logic                  o_q
);

  localparam logic [REM_W-1:0] c_STRIDE = REM_W'(STRIDE);

  logic [REM_W-1:0] w_shift;

  // Incoming remainder is always < STRIDE, so its top bit is free to shift out.
  assign w_shift = {i_rem[REM_W-2:0], i_bit};
  assign o_q     = (w_shift >= c_STRIDE);
  assign o_rem   = o_q ? (w_shift - c_STRIDE) : w_shift;

endmodule
`default_nettype wire

// File: rtl/ddr_addr_to_index.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ddr_addr_to_index : DDR word address -> line index / sub-word offset |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ddr_addr_to_index
  import ddr_index_pkg::*;
(
  input  wire logic          clk,
  input  wire logic          reset_n,
  ddr_addr_to_index_if.slave bus
);

  localparam logic [ADDR_W-1:0]  c_OOR_BASE  = ADDR_W'(OOR_BASE);
  localparam logic [INDEX_W-1:0] c_INDEX_MAX = INDEX_W'(INDEX_MAX);
  localparam logic [CNT_W-1:0]   c_CNT_LAST  = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0]   c_CNT_ONE   = CNT_W'(1);

  state_t             r_state;
  logic [ADDR_W-1:0]  r_addr;
  logic [REM_W-1:0]   r_rem;
  logic [INDEX_W-1:0] r_quot;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_oor;
  logic               r_out_valid;
  logic [INDEX_W-1:0] r_out_index;
  logic [OFF_W-1:0]   r_out_offset;
  logic               r_out_oor;

  logic               w_in_ready;
  logic               w_accept;
  logic [ADDR_W-1:0]  w_addr_shl;
  logic               w_bit;
  logic [REM_W-1:0]   w_rem_next;
  logic               w_q;

  assign w_in_ready = (r_state == IDLE) || ((r_state == DONE) && bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;

  // MSB-first dividend bit for the current step
  assign w_addr_shl = r_addr << r_cnt;
  assign w_bit      = w_addr_shl[ADDR_W-1];

  ddr_div_step u_step (
    .i_rem (r_rem),
    .i_bit (w_bit),
    .o_rem (w_rem_next),
    .o_q   (w_q)
  );

  // Quotient never exceeds 682, so only INDEX_W bits are kept; the upper
  // quotient bits shifted out are always zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_rem        <= '0;
      r_quot       <= '0;
      r_cnt        <= '0;
      r_oor        <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_index  <= '0;
      r_out_offset <= '0;
      r_out_oor    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: ;
        DIV: begin
          // ADDR_W steps, then one edge to register the result
          if (r_cnt == c_CNT_LAST) begin
            r_out_valid  <= 1'b1;
            r_out_index  <= r_oor ? c_INDEX_MAX : r_quot;
            r_out_offset <= r_oor ? '0 : r_rem[OFF_W-1:0];
            r_out_oor    <= r_oor;
            r_state      <= DONE;
          end else begin
            r_rem  <= w_rem_next;
            r_quot <= {r_quot[INDEX_W-2:0], w_q};
            r_cnt  <= r_cnt + c_CNT_ONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      // A new accept overrides the IDLE/DONE transition above
      if (w_accept) begin
        r_addr  <= bus.in_addr;
        r_oor   <= (bus.in_addr >= c_OOR_BASE);
        r_rem   <= '0;
        r_quot  <= '0;
        r_cnt   <= '0;
        r_state <= DIV;
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_index  = r_out_index;
  assign bus.out_offset = r_out_offset;
  assign bus.out_oor    = r_out_oor;
  assign bus.busy       = (r_state == DIV);

endmodule
`default_nettype wire

// File: tb/tb_ddr_addr_to_index.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ddr_addr_to_index : directed bench for ddr_addr_to_index          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_ddr_addr_to_index;

  logic clk;
  logic reset_n;
  int   n_assert;
  int   n_fail;

  ddr_addr_to_index_if bus ();

  ddr_addr_to_index dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // {index, offset, oor}
  function automatic logic [31:0] model(input int a);
    if (a < 4080) return {18'd0, 10'(a / 6), 3'(a % 6), 1'b0};
    else          return {18'd0, 10'd680, 3'd0, 1'b1};
  endfunction

  function automatic logic [31:0] observed();
    return {18'd0, bus.out_index, bus.out_offset, bus.out_oor};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present addr, wait (bounded) for in_ready, return after the accept edge
  task automatic send(input logic [11:0] addr);
    int budget;
    bus.in_valid = 1'b1;
    bus.in_addr  = addr;
    budget = 0;
    while (!bus.in_ready && budget < 40) begin
      tick();
      budget++;
    end
    check("send_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  int          lat;
  logic [31:0] held;
  int          stall;

  initial begin
    n_assert     = 0;
    n_fail       = 0;
    reset_n      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_addr  = '0;
    bus.out_ready = 1'b1;

    repeat (3) tick();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result",    observed(),         32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    reset_n = 1'b1;
    tick();

    // Zero address and latency
    send(12'h000);
    check("t1_busy", 32'(bus.busy), 32'd1);
    wait_result(lat);
    check("t1_latency", 32'(lat), 32'd13);
    check("t1_result", observed(), {18'd0, 10'd0, 3'd0, 1'b0});
    tick();
    check("t1_consumed", 32'(bus.out_valid), 32'd0);

    // Top of range and a mid value
    send(12'hFEF);
    wait_result(lat);
    check("t2_latency", 32'(lat), 32'd13);
    check("t2_fef", observed(), {18'd0, 10'd679, 3'd5, 1'b0});
    tick();
    send(12'h661);
    wait_result(lat);
    check("t2_661", observed(), {18'd0, 10'd272, 3'd1, 1'b0});
    tick();

    // Out-of-range clamp
    send(12'hFF0);
    wait_result(lat);
    check("t3_ff0_latency", 32'(lat), 32'd13);
    check("t3_ff0", observed(), {18'd0, 10'd680, 3'd0, 1'b1});
    tick();
    send(12'hFFF);
    wait_result(lat);
    check("t3_fff_latency", 32'(lat), 32'd13);
    check("t3_fff", observed(), {18'd0, 10'd680, 3'd0, 1'b1});
    tick();

    // Backpressure hold, then back-to-back accept
    bus.out_ready = 1'b0;
    send(12'h019);
    wait_result(lat);
    check("t4_result", observed(), {18'd0, 10'd4, 3'd1, 1'b0});
    held = observed();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_hold_valid", 32'(bus.out_valid), 32'd1);
      check("t4_hold_data",  observed(),         held);
      check("t4_in_ready",   32'(bus.in_ready),  32'd0);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_addr   = 12'h006;
    #1;
    check("t4_b2b_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check("t4_b2b_drop", 32'(bus.out_valid), 32'd0);
    check("t4_b2b_busy", 32'(bus.busy),      32'd1);
    wait_result(lat);
    check("t4_b2b_latency", 32'(lat), 32'd13);
    check("t4_b2b_result", observed(), {18'd0, 10'd1, 3'd0, 1'b0});
    tick();

    // Asynchronous reset in the middle of a divide
    send(12'h123);
    repeat (5) tick();
    check("t5_busy_pre", 32'(bus.busy), 32'd1);
    check("t5_prev_index", 32'(bus.out_index), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("t5_async_result", observed(),        32'd0);
    check("t5_async_valid",  32'(bus.out_valid), 32'd0);
    check("t5_async_busy",   32'(bus.busy),      32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check("t5_in_ready", 32'(bus.in_ready), 32'd1);
    send(12'h00B);
    wait_result(lat);
    check("t5_latency", 32'(lat), 32'd13);
    check("t5_00b", observed(), {18'd0, 10'd1, 3'd5, 1'b0});
    tick();

    // Full sweep with random output stalls and back-to-back accepts
    bus.out_ready = 1'b0;
    send(12'h000);
    for (int a = 0; a < 4096; a++) begin
      wait_result(lat);
      check("sweep_latency", 32'(lat), 32'd13);
      stall = $urandom_range(0, 2);
      repeat (stall) tick();
      check("sweep_result", observed(), model(a));
      bus.out_ready = 1'b1;
      if (a < 4095) begin
        bus.in_valid = 1'b1;
        bus.in_addr  = 12'(a + 1);
      end
      tick();
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      check("sweep_consumed", 32'(bus.out_valid), 32'd0);
    end
    repeat (20) tick();
    check("sweep_no_extra", 32'(bus.out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
